ntsc_cvbs_enc: RTL and testbench
================================

// Module: ntsc_cvbs_enc
// PURPOSE
//  Composite (CVBS) encoder directly downstream of the NTSC timing generator.
//  - Takes the TG sync, blank, burst and field outputs plus a pixel stream (Y/Cb/Cr, 8 bit each).
//  - Produces a 10-bit DAC code at 4fsc: sync tip, blanking, colour burst, and active video as luma plus QAM chroma.
//  - Pixel inputs are sample-aligned with the TG outputs on the same CK_EE_i cycle.
// PARAMETERS
//  C_LVL_SYNC   16    DAC code of the sync tip (-40 IRE)
//  C_LVL_BLANK  240   DAC code of blanking (0 IRE)
//  C_LVL_BLACK  282   DAC code of black (7.5 IRE setup)
//  C_Y_GAIN     606   luma gain, Q8: (Y-16)*C_Y_GAIN>>8 is added to C_LVL_BLACK
//  C_U_GAIN     516   Cb gain, Q8, signed multiply
//  C_V_GAIN     728   Cr gain, Q8, signed multiply
//  C_BURST_AMP  56    burst peak in codes (±10 IRE)
// PORTS
//  CK_i        in   1   4fsc clock
//  XAR_i       in   1   asynchronous reset, active low
//  XR_i        in   1   synchronous clear of subcarrier phase, active low (tri1)
//  CK_EE_i     in   1   clock enable; tie 1 at native 4fsc (tri1)
//  XSYNC_i     in   1   0 = sync, from TG
//  BLANK_i     in   1   1 = blank, from TG
//  BURST_i     in   1   1 = burst window, from TG
//  COLOR_KILL_i in  1   1 = force chroma and burst to zero
//  Y_i         in   8   luma, nominal range 16..235
//  CB_i        in   8   Cb, offset 128
//  CR_i        in   8   Cr, offset 128
//  CVBS_o      out  10  composite DAC code, unsigned
//  SYNC_o      out  1   XSYNC_i delayed by the pipeline latency (0 = sync)
// BEHAVIOUR
//  - Every register advances only when CK_EE_i=1. CK_EE_i=0 holds all state, including the phase counter.
//  - Reset (XAR_i=0):
//    - CVBS_o = C_LVL_BLANK, SYNC_o = 1
//    - delayed sync/blank/burst = 1/1/0
//    - PH = 0; all data registers = 0
//  - Subcarrier phase PH (2 bit):
//    - +1 mod 4 per enabled cycle; cleared to 0 when XR_i=0, in lockstep with the TG counters.
//    - Wraps 3->0 with no gap. 910 clk/line makes PH invert line to line with no special handling.
//  - Latency is exactly 3 enabled cycles, input to CVBS_o/SYNC_o, for data and timing alike. PH is sampled at input time.
//  - S1: register the inputs and PH.
//    - Clamp Y to 16..235; yo = Y-16 (8 bit unsigned).
//    - u = CB-128, v = CR-128 (signed 9 bit).
//  - S2: multiply, then arithmetic shift >>>8 (floor).
//    - yl = C_LVL_BLACK + (yo*C_Y_GAIN>>8)
//    - us = u*C_U_GAIN>>>8, vs = v*C_V_GAIN>>>8
//    - c selected by PH: 0:+us  1:+vs  2:-us  3:-vs
//    - b selected by PH: 0:-C_BURST_AMP  1:0  2:+C_BURST_AMP  3:0
//    - COLOR_KILL (sampled in S1) forces c=0 and b=0.
//  - S3: output mux, priority high to low:
//    - sync=0 -> C_LVL_SYNC
//    - blank&burst -> C_LVL_BLANK + b
//    - blank -> C_LVL_BLANK
//    - else -> yl + c
//    - Compute in signed 12 bit; clamp to 0..1023.
//  - BURST_i is honoured only while BLANK_i=1. Sync overrides burst and blank when they coincide.
//  - XR_i low mid-line clears PH only; the pipeline keeps flowing. XAR_i mid-line resets immediately and asynchronously.
//  - FI is not needed: colour-frame alternation follows from the free-running PH.
// STRUCTURE
//  - Shared package/include ntsc_pkg.vh: the C_LVL_* constants, C_BURST_AMP, and the gain defaults. The TG and the encoder share these.
//  - One sub-module, ntsc_chroma_mod: PH counter plus the S1/S2 chroma/burst path, outputting signed c and b.
//  - Luma path and output mux stay in the top.
// TESTING
//  - Reset: hold XAR_i=0 -> CVBS_o=240, SYNC_o=1; release -> unchanged until the first data emerges 3 cycles later.
//  - XSYNC_i=0 with any pixel -> CVBS_o=16 three cycles later. BLANK_i=1, BURST_i=0 -> 240.
//  - Active, Y=16, Cb=Cr=128 -> 282 constant. Y=235 -> 800. Y=255 -> 800 (clamped).
//  - After an XR_i pulse, BLANK_i=BURST_i=1 -> CVBS_o sequence 184,240,296,240 repeating.
//    - With COLOR_KILL_i=1 -> constant 240.
//  - Y=235, Cr=240, Cb=128 -> PH1 sample 1023 (clamp of 1118), PH3 sample 482.
//    - With Y=16, Cr=16 -> PH1 0 (clamped), PH3 601.
//  - Toggle CK_EE_i 1/0 every cycle on a burst pattern -> the same 184,240,296,240 sequence at half rate; outputs hold while enable is 0.

Source files
------------

// File: rtl/ntsc_cvbs_enc_pkg.sv
// Shared NTSC levels, gains and stage bundles.
// Used by the timing generator and the CVBS encoder.
package ntsc_cvbs_enc_pkg;

  localparam int C_LVL_SYNC  = 16;
  localparam int C_LVL_BLANK = 240;
  localparam int C_LVL_BLACK = 282;
  localparam int C_Y_GAIN    = 606;
  localparam int C_U_GAIN    = 516;
  localparam int C_V_GAIN    = 728;
  localparam int C_BURST_AMP = 56;

  typedef struct packed {
    logic xsync;
    logic blank;
    logic burst;
  } tim_t;

  localparam tim_t TIM_RST = '{xsync: 1'b1, blank: 1'b1, burst: 1'b0};

  function automatic logic [9:0] clamp10(
    input logic signed [11:0] x
  );
    if (x < 0)
      return 10'd0;
    else if (x > 12'sd1023)
      return 10'd1023;
    else
      return x[9:0];
  endfunction

endpackage

// File: rtl/ntsc_chroma_mod.sv
// Subcarrier phase counter plus S1/S2 chroma and burst path.
// Ports: clk/rst_n/en/clr_n, kill, cb, cr in; signed c, b out.
module ntsc_chroma_mod
  import ntsc_cvbs_enc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr_n,
  input  logic               kill,
  input  logic [7:0]         cb,
  input  logic [7:0]         cr,
  output logic signed [11:0] c,
  output logic signed [11:0] b
);

  logic [1:0]        ph;
  logic [1:0]        ph1;
  logic              kill1;
  logic signed [8:0] u1;
  logic signed [8:0] v1;

  logic signed [19:0] up;
  logic signed [19:0] vp;
  logic signed [11:0] us;
  logic signed [11:0] vs;
  logic signed [11:0] c_nx;
  logic signed [11:0] b_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph    <= '0;
      ph1   <= '0;
      kill1 <= 1'b0;
      u1    <= '0;
      v1    <= '0;
      c     <= '0;
      b     <= '0;
    end else if (en) begin
      ph    <= clr_n ? ph + 2'd1 : 2'd0;
      ph1   <= ph;
      kill1 <= kill;
      u1    <= $signed({1'b0, cb}) - 9'sd128;
      v1    <= $signed({1'b0, cr}) - 9'sd128;
      c     <= c_nx;
      b     <= b_nx;
    end
  end

  // Top bits of the product give the floor of >>>8.
  assign up = $signed({{11{u1[8]}}, u1}) * 20'(C_U_GAIN);
  assign vp = $signed({{11{v1[8]}}, v1}) * 20'(C_V_GAIN);
  assign us = up[19:8];
  assign vs = vp[19:8];

  always_comb begin
    c_nx = '0;
    b_nx = '0;
    if (!kill1) begin
      unique case (ph1)
        2'd0: begin
          c_nx = us;
          b_nx = -12'(C_BURST_AMP);
        end
        2'd1: c_nx = vs;
        2'd2: begin
          c_nx = -us;
          b_nx = 12'(C_BURST_AMP);
        end
        default: c_nx = -vs;
      endcase
    end
  end

endmodule

// File: rtl/ntsc_cvbs_enc.sv
// NTSC composite encoder: sync, blank, burst, luma + QAM chroma.
// Ports: CK_i, XAR_i, XR_i, CK_EE_i, TG timing, Y/CB/CR in; CVBS_o, SYNC_o.
module ntsc_cvbs_enc
  import ntsc_cvbs_enc_pkg::*;
(
  input  logic       CK_i,
  input  logic       XAR_i,
  input  logic       XR_i,
  input  logic       CK_EE_i,
  input  logic       XSYNC_i,
  input  logic       BLANK_i,
  input  logic       BURST_i,
  input  logic       COLOR_KILL_i,
  input  logic [7:0] Y_i,
  input  logic [7:0] CB_i,
  input  logic [7:0] CR_i,
  output logic [9:0] CVBS_o,
  output logic       SYNC_o
);

  tim_t              tim1;
  tim_t              tim2;
  logic [7:0]        yo1;
  logic [7:0]        yo_nx;
  logic [17:0]       yp;
  logic signed [11:0] yl2;
  logic signed [11:0] yl_nx;
  logic signed [11:0] c2;
  logic signed [11:0] b2;
  logic signed [11:0] sum;

  ntsc_chroma_mod u_chroma (
    .clk   (CK_i),
    .rst_n (XAR_i),
    .en    (CK_EE_i),
    .clr_n (XR_i),
    .kill  (COLOR_KILL_i),
    .cb    (CB_i),
    .cr    (CR_i),
    .c     (c2),
    .b     (b2)
  );

  always_comb begin
    yo_nx = '0;
    if (Y_i > 8'd235)
      yo_nx = 8'd219;
    else if (Y_i >= 8'd16)
      yo_nx = Y_i - 8'd16;
  end

  assign yp    = 18'(yo1) * 18'(C_Y_GAIN);
  assign yl_nx = 12'(C_LVL_BLACK) + 12'(yp[17:8]);

  always_comb begin
    sum = yl2 + c2;
    if (!tim2.xsync)
      sum = 12'(C_LVL_SYNC);
    else if (tim2.blank && tim2.burst)
      sum = 12'(C_LVL_BLANK) + b2;
    else if (tim2.blank)
      sum = 12'(C_LVL_BLANK);
  end

  always_ff @(posedge CK_i or negedge XAR_i) begin
    if (!XAR_i) begin
      tim1   <= TIM_RST;
      tim2   <= TIM_RST;
      yo1    <= '0;
      yl2    <= '0;
      CVBS_o <= 10'(C_LVL_BLANK);
      SYNC_o <= 1'b1;
    end else if (CK_EE_i) begin
      tim1   <= '{xsync: XSYNC_i, blank: BLANK_i,
                  burst: BURST_i};
      tim2   <= tim1;
      yo1    <= yo_nx;
      yl2    <= yl_nx;
      CVBS_o <= clamp10(sum);
      SYNC_o <= tim2.xsync;
    end
  end

endmodule

// File: tb/tb_ntsc_cvbs_enc.sv
// Directed bench for ntsc_cvbs_enc: table of vectors plus
// reset, clock-enable and async-reset sequences.
module tb_ntsc_cvbs_enc;

  logic       CK_i = 1'b0;
  logic       XAR_i = 1'b0;
  logic       XR_i = 1'b1;
  logic       CK_EE_i = 1'b1;
  logic       XSYNC_i = 1'b1;
  logic       BLANK_i = 1'b1;
  logic       BURST_i = 1'b0;
  logic       COLOR_KILL_i = 1'b0;
  logic [7:0] Y_i = 8'd16;
  logic [7:0] CB_i = 8'd128;
  logic [7:0] CR_i = 8'd128;
  logic [9:0] CVBS_o;
  logic       SYNC_o;

  int n_tot = 0;
  int n_pass = 0;

  always #5 CK_i = ~CK_i;

  ntsc_cvbs_enc dut (
    .CK_i         (CK_i),
    .XAR_i        (XAR_i),
    .XR_i         (XR_i),
    .CK_EE_i      (CK_EE_i),
    .XSYNC_i      (XSYNC_i),
    .BLANK_i      (BLANK_i),
    .BURST_i      (BURST_i),
    .COLOR_KILL_i (COLOR_KILL_i),
    .Y_i          (Y_i),
    .CB_i         (CB_i),
    .CR_i         (CR_i),
    .CVBS_o       (CVBS_o),
    .SYNC_o       (SYNC_o)
  );

  typedef struct {
    logic       xs;
    logic       bl;
    logic       bu;
    logic       ck;
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
    logic [9:0] cv;
  } vec_t;

  localparam int N = 40;
  vec_t tbl[N];

  task automatic chk(input string nm, input int i,
                     input logic [9:0] got, input logic [9:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %0d want %0d", nm, i, got, exp);
  endtask

  task automatic drive(input logic xs, input logic bl,
                       input logic bu, input logic ck,
                       input logic [7:0] y, input logic [7:0] cb,
                       input logic [7:0] cr);
    XSYNC_i = xs; BLANK_i = bl; BURST_i = bu;
    COLOR_KILL_i = ck; Y_i = y; CB_i = cb; CR_i = cr;
  endtask

  task automatic idle();
    drive(1, 1, 0, 0, 8'd16, 8'd128, 8'd128);
  endtask

  task automatic step();
    @(posedge CK_i);
    #1;
  endtask

  function automatic vec_t mk(logic xs, logic bl, logic bu, logic ck,
                              int y, int cb, int cr, int cv);
    vec_t v;
    v.xs = xs; v.bl = bl; v.bu = bu; v.ck = ck;
    v.y = 8'(y); v.cb = 8'(cb); v.cr = 8'(cr); v.cv = 10'(cv);
    return v;
  endfunction

  int bseq[4] = '{184, 240, 296, 240};
  int e;
  logic [9:0] exp_hold;

  initial begin
    // Vector i is sampled with PH = i mod 4.
    for (int i = 0; i < 4; i++)
      tbl[i] = mk(0, 0, 0, 0, 100 + i * 40, 60, 200, 16);
    for (int i = 4; i < 8; i++)
      tbl[i] = mk(1, 1, 0, 0, 235, 240, 16, 240);
    for (int i = 8; i < 12; i++)
      tbl[i] = mk(1, 1, 1, 0, 16, 128, 128, bseq[i % 4]);
    for (int i = 12; i < 16; i++)
      tbl[i] = mk(1, 1, 1, 1, 16, 128, 128, 240);
    for (int i = 16; i < 20; i++)
      tbl[i] = mk(1, 0, 0, 0, 16, 128, 128, 282);
    tbl[20] = mk(1, 0, 0, 0, 235, 128, 128, 800);
    tbl[21] = mk(1, 0, 0, 0, 255, 128, 128, 800);
    tbl[22] = mk(1, 0, 0, 0, 0, 128, 128, 282);
    tbl[23] = mk(1, 0, 0, 0, 235, 128, 240, 482);
    tbl[24] = mk(1, 0, 0, 0, 235, 128, 240, 800);
    tbl[25] = mk(1, 0, 0, 0, 235, 128, 240, 1023);
    tbl[26] = mk(1, 0, 0, 0, 235, 128, 240, 800);
    tbl[27] = mk(1, 0, 0, 0, 16, 128, 16, 601);
    tbl[28] = mk(1, 0, 0, 0, 16, 128, 16, 282);
    tbl[29] = mk(1, 0, 0, 0, 16, 128, 16, 0);
    tbl[30] = mk(0, 1, 1, 0, 200, 240, 240, 16);
    tbl[31] = mk(1, 0, 1, 0, 16, 128, 128, 282);
    tbl[32] = mk(1, 0, 0, 0, 16, 240, 128, 507);
    tbl[33] = mk(1, 0, 0, 0, 16, 240, 128, 282);
    tbl[34] = mk(1, 0, 0, 0, 16, 240, 128, 57);
    tbl[35] = mk(1, 0, 0, 1, 16, 240, 240, 282);
    tbl[36] = mk(1, 0, 0, 0, 16, 16, 128, 56);
    tbl[37] = mk(1, 0, 0, 0, 16, 16, 128, 282);
    tbl[38] = mk(1, 0, 0, 0, 16, 16, 128, 508);
    tbl[39] = mk(1, 0, 0, 0, 16, 16, 128, 282);

    // Reset state and first-data latency.
    idle();
    repeat (3) @(negedge CK_i);
    chk("rst_cvbs", 0, CVBS_o, 10'd240);
    chk("rst_sync", 0, 10'(SYNC_o), 10'd1);
    XAR_i = 1'b1;
    drive(0, 0, 0, 0, 8'd128, 8'd128, 8'd128);
    step();
    idle();
    chk("lat_cvbs", 0, CVBS_o, 10'd240);
    chk("lat_sync", 0, 10'(SYNC_o), 10'd1);
    step();
    chk("lat_cvbs", 1, CVBS_o, 10'd240);
    chk("lat_sync", 1, 10'(SYNC_o), 10'd1);
    step();
    chk("lat_cvbs", 2, CVBS_o, 10'd16);
    chk("lat_sync", 2, 10'(SYNC_o), 10'd0);

    // Table: XR pulse aligns PH, then vector i lands after edge i+2.
    @(negedge CK_i);
    XR_i = 1'b0;
    step();
    @(negedge CK_i);
    XR_i = 1'b1;
    for (int i = 0; i < N + 2; i++) begin
      if (i < N)
        drive(tbl[i].xs, tbl[i].bl, tbl[i].bu, tbl[i].ck,
              tbl[i].y, tbl[i].cb, tbl[i].cr);
      else
        idle();
      step();
      if (i >= 2) begin
        chk("vec_cvbs", i - 2, CVBS_o, tbl[i - 2].cv);
        chk("vec_sync", i - 2, 10'(SYNC_o), 10'(tbl[i - 2].xs));
      end
      @(negedge CK_i);
    end

    // Half-rate enable on a burst pattern.
    idle();
    repeat (3) step();
    @(negedge CK_i);
    XR_i = 1'b0;
    step();
    @(negedge CK_i);
    XR_i = 1'b1;
    drive(1, 1, 1, 0, 8'd16, 8'd128, 8'd128);
    e = 0;
    exp_hold = 10'd240;
    for (int k = 0; k < 20; k++) begin
      CK_EE_i = (k % 2 == 0);
      step();
      if (CK_EE_i) begin
        exp_hold = (e < 2) ? 10'd240 : 10'(bseq[(e - 2) % 4]);
        e++;
      end
      chk("ckee_cvbs", k, CVBS_o, exp_hold);
      @(negedge CK_i);
    end
    CK_EE_i = 1'b1;

    // Asynchronous reset mid-line.
    drive(1, 0, 0, 0, 8'd235, 8'd128, 8'd128);
    repeat (4) step();
    chk("act_cvbs", 0, CVBS_o, 10'd800);
    @(negedge CK_i);
    #2;
    XAR_i = 1'b0;
    #1;
    chk("arst_cvbs", 0, CVBS_o, 10'd240);
    chk("arst_sync", 0, 10'(SYNC_o), 10'd1);
    @(negedge CK_i);
    XAR_i = 1'b1;
    step();
    chk("arst_hold", 0, CVBS_o, 10'd240);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
